// File: rtl/mem_access_unit_if.sv
// CPU-side request/response and sram-side signals of the load/store unit.
// slave: the unit itself. master: the environment (core memory stage plus sram).
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_ready;
    logic                  cpu_we;
    logic [1:0]            cpu_size;
    logic                  cpu_unsigned;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_done;
    logic                  cpu_err;
    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ready, cpu_rdata, cpu_done, cpu_err, mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ready, cpu_rdata, cpu_done, cpu_err, mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: one request at a time, aligned/extended loads,
// read-modify-write for sub-word stores, misaligned/illegal requests flagged
// without any sram access.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_MERGE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] base;

    // Misaligned half/word or the reserved size code.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed lane out of the sram word and sign/zero extend it.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic signed [7:0]            b;
        logic signed [15:0]           h;
        logic signed [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        s = '0;
        r = word;
        case (size)
            SZ_BYTE: begin
                s = b;
                r = uns ? {{(DATA_WIDTH-8){1'b0}}, b} : s;
            end
            SZ_HALF: begin
                s = h;
                r = uns ? {{(DATA_WIDTH-16){1'b0}}, h} : s;
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the target lane of the old sram word with the low store bits.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            lane,
        input logic [1:0]            size
    );
        logic [DATA_WIDTH-1:0] m;
        m = word;
        case (size)
            SZ_BYTE: m[{lane, 3'b000} +: 8]    = wdata[7:0];
            SZ_HALF: m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

    assign accept = bus.cpu_req & (state_q == S_IDLE);
    assign base   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // Next state and load-result register update.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad(bus.cpu_size, bus.cpu_addr[1:0])) begin
                        state_d = S_ERR;
                        rdata_d = '0;
                    end else if (!bus.cpu_we) begin
                        state_d = S_READ;
                    end else if (bus.cpu_size == SZ_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:    state_d = we_q ? S_MERGE : S_CAPTURE;
            S_CAPTURE: begin
                rdata_d = load_extend(bus.mem_rdata, addr_q[1:0], size_q, uns_q);
                state_d = S_DONE;
            end
            S_MERGE:   state_d = S_DONE;
            S_WRITE:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Request fields are latched only on acceptance and held for the whole access.
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = bus.cpu_addr;
            size_d  = bus.cpu_size;
            we_d    = bus.cpu_we;
            uns_d   = bus.cpu_unsigned;
            wdata_d = bus.cpu_wdata;
        end
    end

    // Control state and the visible load result, cleared by async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured request fields; only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        we_q    <= we_d;
        uns_q   <= uns_d;
        wdata_q <= wdata_d;
    end

    // Outputs decoded from state so sram strobes drop as soon as reset asserts.
    always_comb begin
        bus.cpu_ready = (state_q == S_IDLE);
        bus.cpu_done  = (state_q == S_DONE) | (state_q == S_ERR);
        bus.cpu_err   = (state_q == S_ERR);
        bus.cpu_rdata = rdata_q;
        bus.mem_en    = (state_q == S_READ) | (state_q == S_MERGE) | (state_q == S_WRITE);
        bus.mem_wr    = (state_q == S_MERGE) | (state_q == S_WRITE);
        bus.mem_addr  = bus.mem_en ? base : '0;
        bus.mem_wdata = '0;
        if (state_q == S_MERGE) begin
            bus.mem_wdata = store_merge(bus.mem_rdata, wdata_q, addr_q[1:0], size_q);
        end else if (state_q == S_WRITE) begin
            bus.mem_wdata = wdata_q;
        end
    end
endmodule
